// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage of the 16-bit WISC-S15 core. Holds the PC, reads word-addressed
//   instruction memory over a req/ready handshake and hands one registered
//   instruction per cycle to decode. Supports decode stall, redirect (flush)
//   and stops fetching once a HALT/ERR word (opcode 4'b1111) is fetched.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   imem_req     out  fetch request (combinational from state/stall/flush)
//   imem_addr    out  fetch address, always equal to the PC
//   imem_ready   in   imem_rdata is valid this cycle
//   imem_rdata   in   fetched instruction word
//   stall        in   decode cannot accept; hold id_* outputs
//   flush        in   redirect: discard held / in-flight instruction
//   redirect_pc  in   new PC, sampled when flush=1
//   id_valid     out  id_instr / id_pc_plus1 valid for decode
//   id_instr     out  instruction to decode
//   id_pc_plus1  out  address of id_instr + 1 (CALL link value)
//   halted       out  HALT fetched; no further requests until flush/reset
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc_plus1,
  output logic               halted
);

  typedef enum logic [0:0] {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [3:0] OPC_HALT = 4'b1111;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_id_valid;
  logic [INSTR_W-1:0]  r_id_instr;
  logic [ADDR_W-1:0]   r_id_pc_plus1;
  logic                r_halted;
  // Keeps imem_req low while in reset; requests begin the cycle after the
  // first clock edge that sees rst_n high.
  logic                r_req_en;

  logic                w_can_load;
  logic                w_req;
  logic                w_xfer;
  logic                w_is_halt;
  logic [ADDR_W-1:0]   w_pc_plus1;

  // A new word may be loaded when the output slot is empty or decode takes it.
  assign w_can_load = !r_id_valid || !stall;
  assign w_req      = r_req_en && (r_state == ST_FETCH) && w_can_load && !flush;
  assign w_xfer     = w_req && imem_ready;
  assign w_is_halt  = (imem_rdata[INSTR_W-1 -: 4] == OPC_HALT);
  // Unsigned wrap-around increment, no overflow flag.
  assign w_pc_plus1 = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign id_valid    = r_id_valid;
  assign id_instr    = r_id_instr;
  assign id_pc_plus1 = r_id_pc_plus1;
  assign halted      = r_halted;

  // Fetch FSM and decode-side output registers; priority flush > transfer > stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_FETCH;
      r_pc          <= RESET_PC;
      r_id_valid    <= 1'b0;
      r_id_instr    <= {INSTR_W{1'b0}};
      r_id_pc_plus1 <= {ADDR_W{1'b0}};
      r_halted      <= 1'b0;
      r_req_en      <= 1'b0;
    end else begin
      r_req_en <= 1'b1;
      if (flush) begin
        // A fetched HALT may have been on a mispredicted path, so a redirect
        // also leaves HALTED. Any concurrent imem_ready is ignored.
        r_id_valid <= 1'b0;
        r_pc       <= redirect_pc;
        r_state    <= ST_FETCH;
        r_halted   <= 1'b0;
      end else if (w_xfer) begin
        r_id_instr    <= imem_rdata;
        r_id_pc_plus1 <= w_pc_plus1;
        r_id_valid    <= 1'b1;
        r_pc          <= w_pc_plus1;
        if (w_is_halt) begin
          r_state  <= ST_HALTED;
          r_halted <= 1'b1;
        end else begin
          r_state  <= r_state;
          r_halted <= r_halted;
        end
      end else if (!stall) begin
        // Decode consumed (or slot was empty) and nothing arrived: bubble.
        r_id_valid <= 1'b0;
      end else begin
        r_id_valid <= r_id_valid;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [15:0] redirect_pc;

  // DUT with RESET_PC = 0
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc_plus1;
  logic        halted;

  // DUT with RESET_PC = 16'hFFFF
  logic        imem_req2;
  logic [15:0] imem_addr2;
  logic        imem_ready2;
  logic [15:0] imem_rdata2;
  logic        id_valid2;
  logic [15:0] id_instr2;
  logic [15:0] id_pc_plus12;
  logic        halted2;

  logic [15:0] mem [0:255];
  int          wait_n;
  int          cnt;
  int          pass_cnt;
  int          total_cnt;

  instr_fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr),
    .id_pc_plus1(id_pc_plus1), .halted(halted)
  );

  instr_fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready2), .imem_rdata(imem_rdata2),
    .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .id_valid(id_valid2), .id_instr(id_instr2),
    .id_pc_plus1(id_pc_plus12), .halted(halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, wait_n wait cycles before ready.
  assign imem_rdata  = mem[imem_addr[7:0]];
  assign imem_ready  = (wait_n == 0) ? 1'b1 : (imem_req && (cnt >= wait_n));
  assign imem_rdata2 = (imem_addr2 == 16'hFFFF) ? 16'hA5A5 : mem[imem_addr2[7:0]];
  assign imem_ready2 = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else if (imem_req && !imem_ready) cnt <= cnt + 1;
    else cnt <= 0;
  end

  task automatic do_reset(input int wn);
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 16'h0000;
    wait_n = wn;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 16'h0000; wait_n = 0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({imem_req, imem_addr, id_valid, id_instr, id_pc_plus1, halted} !==
        {1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0}) begin
      $display("FAIL reset_outputs: got req=%b addr=%h v=%b instr=%h pc1=%h h=%b, expected all zero",
               imem_req, imem_addr, id_valid, id_instr, id_pc_plus1, halted);
    end else pass_cnt++;
    total_cnt++;
    if ({imem_req2, imem_addr2} !== {1'b0, 16'hFFFF}) begin
      $display("FAIL reset_pc_ffff: got req=%b addr=%h, expected req=0 addr=ffff", imem_req2, imem_addr2);
    end else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (imem_req !== 1'b0) begin
      $display("FAIL reset_release_req: got %b expected 0", imem_req);
    end else pass_cnt++;
  endtask

  task automatic test_zero_wait();
    logic [15:0] exp_instr [0:3];
    logic [15:0] exp_pc1;
    exp_instr[0] = 16'h1123; exp_instr[1] = 16'h2456;
    exp_instr[2] = 16'h3789; exp_instr[3] = 16'h4ABC;
    do_reset(0);
    next_cycle();
    total_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      $display("FAIL zw_first_req: got req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr);
    end else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      exp_pc1 = 16'(k + 1);
      total_cnt++;
      if ({id_valid, id_instr, id_pc_plus1, imem_addr} !== {1'b1, exp_instr[k], exp_pc1, exp_pc1}) begin
        $display("FAIL zw_stream_%0d: got v=%b instr=%h pc1=%h addr=%h expected v=1 instr=%h pc1=%h addr=%h",
                 k, id_valid, id_instr, id_pc_plus1, imem_addr, exp_instr[k], exp_pc1, exp_pc1);
      end else pass_cnt++;
    end
  endtask

  task automatic test_wait_states();
    logic        exp_v;
    logic [15:0] exp_a;
    do_reset(2);
    for (int i = 1; i <= 7; i++) begin
      next_cycle();
      exp_v = (i == 4) || (i == 7);
      exp_a = (i <= 3) ? 16'h0000 : ((i <= 6) ? 16'h0001 : 16'h0002);
      total_cnt++;
      if ({imem_req, imem_addr, id_valid} !== {1'b1, exp_a, exp_v}) begin
        $display("FAIL wait_cycle_%0d: got req=%b addr=%h v=%b expected req=1 addr=%h v=%b",
                 i, imem_req, imem_addr, id_valid, exp_a, exp_v);
      end else pass_cnt++;
    end
    total_cnt++;
    if (id_instr !== 16'h2456) begin
      $display("FAIL wait_second_instr: got %h expected 2456", id_instr);
    end else pass_cnt++;
  endtask

  task automatic test_stall();
    do_reset(0);
    next_cycle();
    next_cycle();
    next_cycle();
    stall = 1'b1;
    #1;
    total_cnt++;
    if ({id_instr, imem_req} !== {16'h2456, 1'b0}) begin
      $display("FAIL stall_entry: got instr=%h req=%b expected instr=2456 req=0", id_instr, imem_req);
    end else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      total_cnt++;
      if ({id_valid, id_instr, id_pc_plus1, imem_req, imem_addr} !==
          {1'b1, 16'h2456, 16'h0002, 1'b0, 16'h0002}) begin
        $display("FAIL stall_hold_%0d: got v=%b instr=%h pc1=%h req=%b addr=%h expected v=1 instr=2456 pc1=0002 req=0 addr=0002",
                 i, id_valid, id_instr, id_pc_plus1, imem_req, imem_addr);
      end else pass_cnt++;
    end
    stall = 1'b0;
    #1;
    total_cnt++;
    if (imem_req !== 1'b1) begin
      $display("FAIL stall_release_req: got %b expected 1", imem_req);
    end else pass_cnt++;
    next_cycle();
    total_cnt++;
    if ({id_valid, id_instr, id_pc_plus1} !== {1'b1, 16'h3789, 16'h0003}) begin
      $display("FAIL stall_after: got v=%b instr=%h pc1=%h expected v=1 instr=3789 pc1=0003",
               id_valid, id_instr, id_pc_plus1);
    end else pass_cnt++;
  endtask

  task automatic test_flush();
    do_reset(0);
    next_cycle();
    next_cycle();
    next_cycle();
    flush = 1'b1;
    redirect_pc = 16'h0040;
    #1;
    total_cnt++;
    if ({imem_addr, imem_ready, imem_req} !== {16'h0002, 1'b1, 1'b0}) begin
      $display("FAIL flush_req_drop: got addr=%h rdy=%b req=%b expected addr=0002 rdy=1 req=0",
               imem_addr, imem_ready, imem_req);
    end else pass_cnt++;
    next_cycle();
    flush = 1'b0;
    #1;
    total_cnt++;
    if ({id_valid, imem_addr, imem_req} !== {1'b0, 16'h0040, 1'b1}) begin
      $display("FAIL flush_redirect: got v=%b addr=%h req=%b expected v=0 addr=0040 req=1",
               id_valid, imem_addr, imem_req);
    end else pass_cnt++;
    next_cycle();
    total_cnt++;
    if ({id_valid, id_instr, id_pc_plus1} !== {1'b1, 16'h6111, 16'h0041}) begin
      $display("FAIL flush_target: got v=%b instr=%h pc1=%h expected v=1 instr=6111 pc1=0041",
               id_valid, id_instr, id_pc_plus1);
    end else pass_cnt++;
  endtask

  task automatic test_halt();
    do_reset(0);
    for (int i = 0; i < 6; i++) next_cycle();
    total_cnt++;
    if ({id_valid, id_instr, halted} !== {1'b1, 16'h5DEF, 1'b0}) begin
      $display("FAIL halt_pre: got v=%b instr=%h h=%b expected v=1 instr=5def h=0", id_valid, id_instr, halted);
    end else pass_cnt++;
    next_cycle();
    total_cnt++;
    if ({id_valid, id_instr, id_pc_plus1, halted, imem_req} !== {1'b1, 16'hF000, 16'h0006, 1'b1, 1'b0}) begin
      $display("FAIL halt_fetched: got v=%b instr=%h pc1=%h h=%b req=%b expected v=1 instr=f000 pc1=0006 h=1 req=0",
               id_valid, id_instr, id_pc_plus1, halted, imem_req);
    end else pass_cnt++;
    stall = 1'b1;
    next_cycle();
    total_cnt++;
    if ({id_valid, id_instr, halted, imem_req} !== {1'b1, 16'hF000, 1'b1, 1'b0}) begin
      $display("FAIL halt_held: got v=%b instr=%h h=%b req=%b expected v=1 instr=f000 h=1 req=0",
               id_valid, id_instr, halted, imem_req);
    end else pass_cnt++;
    stall = 1'b0;
    next_cycle();
    total_cnt++;
    if ({id_valid, halted, imem_req} !== {1'b0, 1'b1, 1'b0}) begin
      $display("FAIL halt_drained: got v=%b h=%b req=%b expected v=0 h=1 req=0", id_valid, halted, imem_req);
    end else pass_cnt++;
    next_cycle();
    flush = 1'b1;
    redirect_pc = 16'h0010;
    #1;
    total_cnt++;
    if ({imem_req, halted} !== {1'b0, 1'b1}) begin
      $display("FAIL halt_flush_req: got req=%b h=%b expected req=0 h=1", imem_req, halted);
    end else pass_cnt++;
    next_cycle();
    flush = 1'b0;
    #1;
    total_cnt++;
    if ({halted, imem_addr, imem_req, id_valid} !== {1'b0, 16'h0010, 1'b1, 1'b0}) begin
      $display("FAIL halt_resume: got h=%b addr=%h req=%b v=%b expected h=0 addr=0010 req=1 v=0",
               halted, imem_addr, imem_req, id_valid);
    end else pass_cnt++;
    next_cycle();
    total_cnt++;
    if ({id_valid, id_instr, id_pc_plus1} !== {1'b1, 16'h7333, 16'h0011}) begin
      $display("FAIL halt_resume_instr: got v=%b instr=%h pc1=%h expected v=1 instr=7333 pc1=0011",
               id_valid, id_instr, id_pc_plus1);
    end else pass_cnt++;
  endtask

  task automatic test_pc_wrap();
    do_reset(0);
    next_cycle();
    total_cnt++;
    if ({imem_req2, imem_addr2} !== {1'b1, 16'hFFFF}) begin
      $display("FAIL wrap_first_addr: got req=%b addr=%h expected req=1 addr=ffff", imem_req2, imem_addr2);
    end else pass_cnt++;
    next_cycle();
    total_cnt++;
    if ({id_valid2, id_instr2, id_pc_plus12, imem_addr2} !== {1'b1, 16'hA5A5, 16'h0000, 16'h0000}) begin
      $display("FAIL wrap_first_instr: got v=%b instr=%h pc1=%h addr=%h expected v=1 instr=a5a5 pc1=0000 addr=0000",
               id_valid2, id_instr2, id_pc_plus12, imem_addr2);
    end else pass_cnt++;
    next_cycle();
    total_cnt++;
    if ({id_instr2, id_pc_plus12} !== {16'h1123, 16'h0001}) begin
      $display("FAIL wrap_second_instr: got instr=%h pc1=%h expected instr=1123 pc1=0001", id_instr2, id_pc_plus12);
    end else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset(2);
    for (int i = 0; i < 4; i++) next_cycle();
    total_cnt++;
    if ({id_valid, id_instr, id_pc_plus1, imem_req, imem_addr} !==
        {1'b1, 16'h1123, 16'h0001, 1'b1, 16'h0001}) begin
      $display("FAIL areset_pre: got v=%b instr=%h pc1=%h req=%b addr=%h expected v=1 instr=1123 pc1=0001 req=1 addr=0001",
               id_valid, id_instr, id_pc_plus1, imem_req, imem_addr);
    end else pass_cnt++;
    #1;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({imem_req, imem_addr, id_valid, id_instr, id_pc_plus1, halted} !==
        {1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0}) begin
      $display("FAIL areset_immediate: got req=%b addr=%h v=%b instr=%h pc1=%h h=%b expected all zero",
               imem_req, imem_addr, id_valid, id_instr, id_pc_plus1, halted);
    end else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    redirect_pc = 16'h0000;
    wait_n = 0;
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    mem[0]     = 16'h1123;
    mem[1]     = 16'h2456;
    mem[2]     = 16'h3789;
    mem[3]     = 16'h4ABC;
    mem[4]     = 16'h5DEF;
    mem[5]     = 16'hF000;
    mem[8'h10] = 16'h7333;
    mem[8'h11] = 16'h7444;
    mem[8'h40] = 16'h6111;
    mem[8'h41] = 16'h6222;

    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_flush();
    test_halt();
    test_pc_wrap();
    test_async_reset();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
